// File: rtl/proj1_alu_seq.sv
// proj1_alu_seq: instruction sequencer in front of the project-1 ALU.
// Takes one instruction at a time over valid/ready, fetches operands from a
// small register file, drives the ALU, waits out its two-stage latency and
// writes the result plus C/N/Z back.
// Optional build macro: PROJ1_ALU_SEQ_ILLEGAL_TRAP_EN traps illegal opcodes
// with a one-cycle err_o pulse instead of issuing them to the ALU.
module proj1_alu_seq #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [7:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rr,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data,
    output logic          done_o,
    output logic          err_o,
    output logic          c_o,
    output logic          n_o,
    output logic          z_o,
    output logic [7:0]    alu_opcode,
    output logic [7:0]    alu_data_rd,
    output logic [7:0]    alu_data_rr,
    output logic          alu_ci,
    input  logic [15:0]   alu_data_o,
    input  logic          alu_co,
    input  logic          alu_no,
    input  logic          alu_zo
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t        state, state_nxt;
    logic [7:0]    regs [NREG];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_hi;
    logic          mul_q;
    logic          illegal_q;
    logic          issue_ok;
    logic          accept;
    logic          ld_take;
    logic [7:0]    opa;
    logic [7:0]    opb;

    assign accept  = instr_valid && instr_ready;
    // Loads are only honoured while the sequencer is idle
    assign ld_take = ld_en && instr_ready;
    // High byte of a multiply goes to the next register, wrapping at NREG
    assign rd_hi   = rd_q + AW'(1);

    // Operands are captured at the accept edge, so a load on that same edge
    // has to be forwarded or the instruction would see the stale value
    assign opa = (ld_take && (ld_addr == instr_rd)) ? ld_data : regs[instr_rd];
    assign opb = (ld_take && (ld_addr == instr_rr)) ? ld_data : regs[instr_rr];

    assign dbg_data = regs[dbg_addr];

`ifdef PROJ1_ALU_SEQ_ILLEGAL_TRAP_EN
    function automatic logic op_legal(input logic [7:0] op);
        logic ok;
        ok = 1'b0;
        case (op[7:4])
            4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b1010: ok = 1'b1;
            4'b1011: ok = (op[1:0] == 2'b00);
            default: ok = (op[7:6] == 2'b11);
        endcase
        return ok;
    endfunction

    assign issue_ok = op_legal(instr_op);

    // Remember whether the accepted instruction must be trapped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= !issue_ok;
        end
    end
`else
    assign issue_ok  = 1'b1;
    assign illegal_q = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed ISSUE/WAIT/WB walk, trapped ops return from ISSUE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = illegal_q ? IDLE : WAIT;
            WAIT:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        instr_ready = (state == IDLE);
        done_o      = (state == WB);
        err_o       = (state == ISSUE) && illegal_q;
    end

    // Latch destination and multiply flag for the writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            mul_q <= 1'b0;
        end else if (accept) begin
            rd_q  <= instr_rd;
            mul_q <= (instr_op[7:4] == 4'b0100);
        end
    end

    // ALU inputs load on accept and then hold through WAIT and WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_opcode  <= '0;
            alu_data_rd <= '0;
            alu_data_rr <= '0;
            alu_ci      <= 1'b0;
        end else if (accept && issue_ok) begin
            alu_opcode  <= instr_op;
            alu_data_rd <= opa;
            alu_data_rr <= opb;
            alu_ci      <= c_o;
        end
    end

    // Register file: idle-time loads and ALU writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_take) begin
                regs[ld_addr] <= ld_data;
            end
            if (state == WB) begin
                regs[rd_q] <= alu_data_o[7:0];
                if (mul_q) begin
                    regs[rd_hi] <= alu_data_o[15:8];
                end
            end
        end
    end

    // Flags update only on writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_o <= 1'b0;
            n_o <= 1'b0;
            z_o <= 1'b0;
        end else if (state == WB) begin
            c_o <= alu_co;
            n_o <= alu_no;
            z_o <= alu_zo;
        end
    end

endmodule

// File: doc/proj1_alu_seq.md
# proj1_alu_seq

Instruction sequencer that drives the project-1 ALU from the issuing side. Accepts one instruction at a time over a valid/ready handshake, reads operands from an internal register file, presents opcode/operands/carry to the ALU, waits out the ALU's two-stage registered latency, then writes the result and the C/N/Z flags back. It sits between the instruction source (testbench or fetch logic) and the ALU.

## Interface
- `NREG`, default 8: register-file depth; must be a power of two.
- `AW`, default 3: register address width, log2(`NREG`).
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: high only in IDLE.
- `instr_op` in 8: ALU opcode.
- `instr_rd` in AW: destination and first-source register.
- `instr_rr` in AW: second-source register.
- `ld_en` in 1: register-file load strobe.
- `ld_addr` in AW: load address.
- `ld_data` in 8: load data.
- `dbg_addr` in AW: debug read address.
- `dbg_data` out 8: combinational read of `regs[dbg_addr]`.
- `done_o` out 1: one-cycle pulse in the writeback cycle.
- `err_o` out 1: one-cycle illegal-opcode pulse (see Configuration).
- `c_o`, `n_o`, `z_o` out 1 each: stored flags.
- `alu_opcode` out 8, `alu_data_rd` out 8, `alu_data_rr` out 8, `alu_ci` out 1: ALU inputs, registered.
- `alu_data_o` in 16, `alu_co` in 1, `alu_no` in 1, `alu_zo` in 1: ALU results.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE: `instr_ready`=1. When `instr_valid` is high, the op, rd, and rr are latched and the FSM goes to ISSUE.
- ISSUE: `alu_opcode`=op, `alu_data_rd`=regs[rd], `alu_data_rr`=regs[rr], `alu_ci`=C. These values hold through WAIT and WB. The ALU registers its inputs at the end of ISSUE.
- WAIT: the ALU registers its outputs at the end of this cycle.
- WB: `done_o`=1. At the end of the cycle:
  - regs[rd] <= `alu_data_o[7:0]`.
  - If op[7:4]==4'b0100 (multiply), regs[(rd+1) mod NREG] <= `alu_data_o[15:8]`.
  - C/N/Z <= `alu_co`/`alu_no`/`alu_zo`.
  - The FSM returns to IDLE.
- Load port: `ld_en` is honoured only while `instr_ready`=1 and is dropped silently otherwise. A load and an accept on the same edge are both taken, and the instruction reads the new value in ISSUE.
- Multiply with rd==rr: both operands come from the same register. The high byte wraps, so rd=NREG-1 writes its high byte to register 0.

## Timing
- Accept edge E0 → ISSUE cycle 1, WAIT cycle 2, WB cycle 3; writeback at edge E3.
- `instr_ready` returns high in cycle 4, giving a throughput of one instruction per 4 cycles.
- A back-to-back instruction held valid is accepted at E4.
- Reset (`rst`=0, asynchronous):
  - All registers, C/N/Z, and ALU-side outputs go to 0.
  - `done_o`=`err_o`=0 and the FSM goes to IDLE.
  - After release, `instr_ready`=1 on the first cycle.
  - Reset during ISSUE/WAIT/WB abandons the instruction with no writeback.

## Configuration
- `PROJ1_ALU_SEQ_ILLEGAL_TRAP_EN` defined: the legal opcodes are 0000xxxx, 0100xxxx, 1000xxxx, 1001xxxx, 1010xxxx, 1011xx00, and 11xxxxxx.
  - An illegal opcode is still accepted.
  - `err_o` pulses in the cycle after acceptance, and the FSM goes back to IDLE without driving the ALU.
  - Registers and flags are unchanged and `done_o` stays 0.
  - Round trip is 2 cycles.
- Undefined: every opcode is issued, and whatever the ALU returns is written back. `err_o` is tied to 0.

## Test plan
- Load R1=0x05, R2=0x03; op 0xC0, rd=1, rr=2 → `done_o` in cycle 3 after accept; R1=0x08, C=0, N=0, Z=0.
- Load R3=0x10, R4=0x20; op 0x40, rd=3, rr=4 → R3=0x00, R4=0x02. Repeat with rd=7, R7=0xFF, rr=7 → R7=0x01, R0=0xFE.
- Carry chain:
  - Add 0xFF+0x01 (rd=1, rr=2) → R1=0x00, C=1, Z=1.
  - Then op 0xD0 with two zero registers → result 0x01, C=0, Z=0.
- ROL (op 0x02) on 0x80 with C=1 → 0x01, C=1. A following ROR (op 0x03) on 0x01 with C=1 → 0x80, C=1, N=1.
- Op 0x20:
  - With the macro: `err_o`=1 for one cycle, no `done_o`, `dbg_data` unchanged, `instr_ready` high again 2 cycles after accept.
  - Without the macro: `done_o` at cycle 3.
- Assert `rst`=0 during WAIT of an add → all registers read 0 via `dbg_data`, C/N/Z=0, no `done_o`; after release, `instr_ready`=1 and a new add completes normally.
